// File: rtl/sum_acc_pkg.sv
// Shared definitions for the sum_acc block accumulator.
//   DATA_W   : width of the sample and result paths
//   state_e  : block state (IDLE / ACC / HOLD)
//   SAT_MAX / SAT_MIN : 32-bit saturation limits used when SUM_ACC_SAT_EN is defined
package sum_acc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/sum_sat.sv
// Combinational clamp of a signed ACC_W-bit accumulator to a signed 32-bit result.
// Only instantiated by sum_acc when SUM_ACC_SAT_EN is defined.
// Ports:
//   acc  (in,  ACC_W)  signed accumulator value
//   data (out, 32)     acc clamped to [-2^31, 2^31-1]
//   clip (out, 1)      1 when the clamp changed the value
module sum_sat
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] data,
  output logic              clip
);

  // The value fits in 32 bits exactly when every bit from bit 31 upward equals the sign.
  logic [ACC_W-DATA_W:0] upper_s;
  logic                  fits_s;

  assign upper_s = acc[ACC_W-1:DATA_W-1];
  assign fits_s  = (&upper_s) | ~(|upper_s);

  // Pick pass-through or the limit matching the accumulator sign.
  always_comb begin
    data = acc[DATA_W-1:0];
    clip = 1'b0;
    if (fits_s) begin
      data = acc[DATA_W-1:0];
      clip = 1'b0;
    end else if (acc[ACC_W-1]) begin
      data = SAT_MIN;
      clip = 1'b1;
    end else begin
      data = SAT_MAX;
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/sum_acc.sv
// sum_acc: sums LEN signed 32-bit samples into one 32-bit block result.
// Optional feature macro: SUM_ACC_SAT_EN (saturate result and report ovf);
// without it the result is the low 32 bits of the sum and ovf is always 0.
// Ports:
//   clk, rst (async active-high), clr (sync block clear)
//   in_data/in_valid/in_ready    : sample input handshake
//   out_data/out_valid/out_ready : block result handshake (held while stalled)
//   ovf                          : sticky saturation flag, cleared by rst or clr
module sum_acc
  import sum_acc_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf
);

  localparam int CNT_W = $clog2(LEN + 1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              ovf_q, ovf_d;

  logic              ready_s;
  logic              accept_s;
  logic              last_s;
  logic [ACC_W-1:0]  acc_sum_s;
  logic [DATA_W-1:0] red_data_s;
  logic              clip_s;

  assign ready_s   = (state_q != HOLD);
  assign accept_s  = in_valid & ready_s;
  assign last_s    = (cnt_q == CNT_W'(LEN - 1));
  assign acc_sum_s = acc_q + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

  // The reduction is taken from the updated sum so the result is ready on HOLD entry.
`ifdef SUM_ACC_SAT_EN
  sum_sat #(
    .ACC_W (ACC_W)
  ) u_sum_sat (
    .acc  (acc_sum_s),
    .data (red_data_s),
    .clip (clip_s)
  );
`else
  assign red_data_s = acc_sum_s[DATA_W-1:0];
  assign clip_s     = 1'b0;
`endif

  // Next-state and datapath update; clr wins over any accept or output handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (clr) begin
      state_d     = IDLE;
      acc_d       = {ACC_W{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      out_data_d  = {DATA_W{1'b0}};
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept_s) begin
            acc_d = acc_sum_s;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_s) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
              out_data_d  = red_data_s;
              ovf_d       = ovf_q | clip_s;
            end else begin
              state_d = ACC;
            end
          end else begin
            state_d = state_q;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d     = IDLE;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            out_valid_d = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // in_ready is gated by rst so nothing looks acceptable while reset is held.
  assign in_ready  = ready_s & ~rst;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule
